// File: rtl/scan_chain_controller.sv
// rtl/scan_chain_controller.sv - byte stream <-> serial scan chain driver
// Exchange passes shift new bytes in; rotate passes loop scan_out back to scan_in.
module scan_chain_controller #(
  parameter int CHAIN_LEN  = 256,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_mode,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_scan_enable,
  output logic                  o_scan_in,
  input  logic                  i_scan_out
);

  localparam int NUM_BYTES = CHAIN_LEN / DATA_WIDTH;
  localparam int BIT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHIFT, S_OUT} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_mode;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [BYTE_W-1:0]     r_byte_cnt;
  logic [DATA_WIDTH-1:0] r_tx;
  logic [DATA_WIDTH-1:0] r_rx;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_in_ready;
  logic                  w_out_valid;
  logic                  w_scan_enable;
  logic                  w_last_bit;
  logic                  w_last_byte;
  logic [DATA_WIDTH-1:0] w_rx_next;

  assign w_last_bit  = (r_bit_cnt == BIT_W'(DATA_WIDTH - 1));
  assign w_last_byte = (r_byte_cnt == BYTE_W'(NUM_BYTES - 1));
  assign w_rx_next   = {r_rx[DATA_WIDTH-2:0], i_scan_out};

  always_comb begin
    w_next_state  = r_state;
    w_in_ready    = 1'b0;
    w_out_valid   = 1'b0;
    w_scan_enable = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next_state = i_mode ? S_SHIFT : S_FETCH;
      end
      S_FETCH: begin
        w_in_ready = 1'b1;
        if (i_in_valid) w_next_state = S_SHIFT;
      end
      S_SHIFT: begin
        w_scan_enable = 1'b1;
        if (w_last_bit) w_next_state = S_OUT;
      end
      S_OUT: begin
        w_out_valid = 1'b1;
        if (i_out_ready) begin
          if (w_last_byte) w_next_state = S_IDLE;
          else             w_next_state = r_mode ? S_SHIFT : S_FETCH;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode     <= 1'b0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_out_data <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mode     <= i_mode;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_busy     <= 1'b1;
          end
        end
        S_FETCH: begin
          if (i_in_valid) r_tx <= i_in_data;
        end
        S_SHIFT: begin
          // First bit captured lands in the MSB after DATA_WIDTH shifts.
          r_rx <= w_rx_next;
          r_tx <= {r_tx[DATA_WIDTH-2:0], 1'b0};
          if (w_last_bit) begin
            r_bit_cnt  <= '0;
            r_out_data <= w_rx_next;
          end else begin
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
          end
        end
        S_OUT: begin
          if (i_out_ready) begin
            if (w_last_byte) begin
              r_byte_cnt <= '0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_byte_cnt <= r_byte_cnt + BYTE_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_in_ready    = w_in_ready;
  assign o_out_valid   = w_out_valid;
  assign o_scan_enable = w_scan_enable;
  // Rotate mode closes the loop combinationally so the chain is restored after a pass.
  assign o_scan_in     = w_scan_enable & (r_mode ? i_scan_out : r_tx[DATA_WIDTH-1]);
  assign o_out_data    = r_out_data;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

endmodule

// File: tb/tb_scan_chain_controller.sv
// tb/tb_scan_chain_controller.sv - directed bench for scan_chain_controller
// A 256-bit shift-chain model on the scan pins supplies every expected byte.
module tb_scan_chain_controller;

  logic       clk = 1'b0;
  logic       rst, start, mode, in_valid, in_ready, out_valid, out_ready;
  logic       busy, done, scan_enable, scan_in, scan_out;
  logic [7:0] in_data, out_data;

  always #5 clk = ~clk;

  scan_chain_controller #(.CHAIN_LEN(256), .DATA_WIDTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode),
    .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .o_out_data(out_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_busy(busy), .o_done(done), .o_scan_enable(scan_enable),
    .o_scan_in(scan_in), .i_scan_out(scan_out)
  );

  logic [255:0] chain, chain_init;
  logic         chain_load;
  always @(posedge clk) begin
    if (chain_load)       chain <= chain_init;
    else if (scan_enable) chain <= {chain[254:0], scan_in};
  end
  assign scan_out = chain[255];

  int se_cnt = 0, busy_cnt = 0, done_cnt = 0, ovl_cnt = 0, rdy_cnt = 0;
  always @(negedge clk) begin
    if (scan_enable)           se_cnt++;
    if (busy)                  busy_cnt++;
    if (done)                  done_cnt++;
    if (in_ready && out_valid) ovl_cnt++;
    if (in_ready)              rdy_cnt++;
  end

  int n_pass = 0, n_total = 0, n_fail = 0;
  logic [7:0] tx_b [32];
  logic [7:0] rx_b [32];
  logic [7:0] exp_b[32];
  logic [7:0] rx_d [32];

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin n_fail++; $error("FAIL %s observed=%b expected=%b", tag, obs, exp); end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin n_fail++; $error("FAIL %s observed=%h expected=%h", tag, obs, exp); end
  endtask

  task automatic check32(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin n_fail++; $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp); end
  endtask

  task automatic check256(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin n_fail++; $error("FAIL %s observed=%h expected=%h", tag, obs, exp); end
  endtask

  task automatic do_pass(input bit m, input bit pre_valid, input bit glitch, input int stall_byte,
                         input int n_in, input int n_out, input int abort_byte, input int exp_busy);
    logic [255:0] snap, nxt;
    logic [7:0]   hold;
    int           se0, b0, t;
    snap = chain;
    for (int k = 0; k < 32; k++) exp_b[k] = snap[255-8*k -: 8];
    se0 = se_cnt;
    b0  = busy_cnt;
    start = 1'b1;
    mode  = m;
    if (pre_valid) begin in_valid = 1'b1; in_data = 8'hEE; end
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    check1("start_busy", busy, 1'b1);
    if (m) check1("start_scan_enable", scan_enable, 1'b1);
    else   check1("start_in_ready", in_ready, 1'b1);
    for (int k = 0; k < 32; k++) begin
      if (!m) begin
        if (k == stall_byte) repeat (n_in) begin
          check1("fetch_stall_se", scan_enable, 1'b0);
          @(negedge clk);
        end
        t = 0;
        while (!in_ready && t < 40) begin @(negedge clk); t++; end
        check1("fetch_reached", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = tx_b[k];
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
      if (k == abort_byte) begin
        repeat (3) @(negedge clk);
        check1("abort_in_shift", scan_enable, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check1("abort_busy", busy, 1'b0);
        check1("abort_se", scan_enable, 1'b0);
        check1("abort_done", done, 1'b0);
        check1("abort_out_valid", out_valid, 1'b0);
        @(negedge clk);
        check1("abort_stays_idle", busy, 1'b0);
        return;
      end
      t = 0;
      while (!out_valid && t < 40) begin @(negedge clk); t++; end
      check1("out_reached", out_valid, 1'b1);
      if (glitch && k == 5) begin start = 1'b1; mode = !m; end
      if (k == stall_byte) begin
        hold = out_data;
        repeat (n_out) begin
          check1("out_stall_se", scan_enable, 1'b0);
          check8("out_stall_data", out_data, hold);
          @(negedge clk);
        end
      end
      rx_b[k]   = out_data;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      start     = 1'b0;
      mode      = m;
      check8("rx_byte", rx_b[k], exp_b[k]);
    end
    check1("done_pulse", done, 1'b1);
    check1("busy_clear", busy, 1'b0);
    check32("busy_cycles", busy_cnt - b0, exp_busy);
    check32("se_cycles", se_cnt - se0, 256);
    nxt = snap;
    if (!m) for (int k = 0; k < 32; k++) nxt[255-8*k -: 8] = tx_b[k];
    check256("chain_after", chain, nxt);
    @(negedge clk);
    check1("done_single", done, 1'b0);
  endtask

  int d0, r0;

  initial begin
    rst        = 1'b1;
    start      = 1'b1;
    mode       = 1'($urandom);
    in_valid   = 1'b1;
    in_data    = 8'($urandom);
    out_ready  = 1'b1;
    chain_load = 1'b1;
    chain_init = 256'h0123456789ABCDEF_FEDCBA9876543210_1122334455667788_99AABBCCDDEEFF00;
    repeat (2) @(negedge clk);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_scan_enable", scan_enable, 1'b0);
    check1("rst_scan_in", scan_in, 1'b0);
    check8("rst_out_data", out_data, 8'h00);
    rst        = 1'b0;
    start      = 1'b0;
    mode       = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    chain_load = 1'b0;
    @(negedge clk);
    check1("post_rst_idle", busy, 1'b0);
    check1("post_rst_no_ready", in_ready, 1'b0);

    d0 = done_cnt;
    for (int k = 0; k < 32; k++) tx_b[k] = 8'(k);
    do_pass(1'b0, 1'b1, 1'b1, -1, 0, 0, -1, 320);
    for (int k = 0; k < 32; k++) tx_b[k] = 8'hFF;
    do_pass(1'b0, 1'b0, 1'b0, -1, 0, 0, -1, 320);
    for (int k = 0; k < 32; k++) check8("pass2_order", rx_b[k], 8'(k));
    check32("exchange_done_count", done_cnt - d0, 2);

    for (int k = 0; k < 32; k++) tx_b[k] = (k[0] ? 8'h3C : 8'hA5) ^ 8'(k >> 1);
    do_pass(1'b0, 1'b0, 1'b0, -1, 0, 0, -1, 320);
    r0 = rdy_cnt;
    do_pass(1'b1, 1'b0, 1'b1, -1, 0, 0, -1, 288);
    for (int k = 0; k < 32; k++) rx_d[k] = rx_b[k];
    do_pass(1'b1, 1'b0, 1'b0, -1, 0, 0, -1, 288);
    check8("rotate_first_byte", rx_d[0], 8'hA5);
    check8("rotate_second_byte", rx_d[1], 8'h3C);
    for (int k = 0; k < 32; k++) check8("rotate_repeat", rx_b[k], rx_d[k]);
    check32("rotate_in_ready_cycles", rdy_cnt - r0, 0);

    for (int k = 0; k < 32; k++) tx_b[k] = 8'(k * 7 + 3);
    do_pass(1'b0, 1'b0, 1'b0, 4, 5, 7, -1, 332);

    d0 = done_cnt;
    do_pass(1'b0, 1'b0, 1'b0, -1, 0, 0, 10, 0);
    check32("abort_no_done", done_cnt - d0, 0);
    for (int k = 0; k < 32; k++) tx_b[k] = 8'(k) ^ 8'h5A;
    do_pass(1'b0, 1'b0, 1'b0, -1, 0, 0, -1, 320);
    do_pass(1'b1, 1'b0, 1'b0, -1, 0, 0, -1, 288);
    for (int k = 0; k < 32; k++) check8("after_abort_readback", rx_b[k], 8'(k) ^ 8'h5A);
    check32("ready_valid_overlap", ovl_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
